i2s_rx_deser: RTL
=================

// Module: i2s_rx_deser
// PURPOSE
//  Serial-data receive path of the I2S transceiver: samples sd with the ws line and assembles
//  left/right words into parallel data. Writes each word into the Rx FIFO.
//  Works in both master-receive (ws from ws_gen) and slave-receive (external ws) modes.
//  The WS timing side decides when slots occur; this block decides what data is in them.
// PARAMETERS
//  DW     32  max word width; fixed at 32 here, f16bits uses the upper 16 bits
// PORTS
//  sclk        in   1   serial bit clock; all flops on posedge sclk (receiver samples on rising edge)
//  preset      in   1   asynchronous, active-low reset
//  rx_en       in   1   receive enable (OP.tran_en qualified by mode MR/SR)
//  frame_size  in   1   0=f16bits, 1=f32bits
//  standard    in   1   0=I2S (MSB one bit after ws edge, ws=0 left), 1=MSB-justified (ws=1 left)
//  stereo      in   1   1=store L and R words, 0=store L only
//  ws          in   1   word select line
//  sd          in   1   serial data
//  rx_full     in   1   Rx FIFO full
//  err_clr     in   1   synchronous clear of sticky error flags
//  rx_wen      out  1   one-cycle FIFO write strobe
//  rx_data     out  32  received word, MSB-aligned; f16bits words in [31:16], [15:0]=0
//  rx_right    out  1   channel tag of rx_data (1=right)
//  overrun     out  1   sticky: word dropped because rx_full
//  slot_err    out  1   sticky: channel slot ended before W bits were received
// BEHAVIOUR
//  Reset: all outputs 0, shift reg 0, bit cnt 0, ws_q = 0, state IDLE.
//  W = 16 or 32 from frame_size. frame_size/standard/stereo are sampled at slot start
//   and held for the whole slot.
//  Each posedge: ws_q<=ws; chg = (ws != ws_q).
//  Slot start edge: MSB-justified = the edge where chg=1, and sd at that edge is the MSB.
//   I2S = the edge after chg=1, and sd at the chg edge is the LSB of the previous slot.
//  Channel of a new slot is taken from the new ws value through the standard mapping.
//  FSM:
//   IDLE : rx_en=0, or waiting after enable. Goes to SYNC when rx_en=1.
//   SYNC : discards bits until the first slot start. Never emits partial words.
//   SHIFT: shreg <= {shreg[30:0], sd}; cnt++. On bit W-1 -> emit, go to HOLD.
//          If the slot ends early -> emit zero-padded word, set slot_err, start the new slot.
//   HOLD : ignores sd until the next slot start, then goes to SHIFT with cnt=0.
//          If rx_en=0 at that point -> IDLE.
//  Emit: on the edge that samples the last bit, register rx_data = bits left-aligned and
//   rx_right = channel. rx_wen=1 for exactly the next cycle.
//   If rx_full is 1 at emit: no rx_wen, overrun<=1, data discarded.
//  stereo=0: right slots are tracked but never emitted (no rx_wen, no errors).
//  Simultaneous events: in I2S, the last-bit edge coincides with the chg edge.
//   The word is emitted normally and the next slot starts on the following edge.
//   No slot_err is raised in this case.
//  rx_en deasserted mid-slot: the current word is finished and emitted, then IDLE.
//  rx_en reasserted: SYNC again.
//  err_clr has priority over a same-cycle error set (flags read 0). Flags otherwise hold until preset.
//  Async reset mid-word: immediate return to reset values. The partial word is lost.
//  Latency: sd bit W-1 sampled at edge n -> rx_wen high during cycle n+1.
// TESTING
//  T1 LJ, f32, stereo: L=0xA5A5_0F0F, R=0x1234_5678 -> two rx_wen pulses with rx_right=0 then 1,
//     exact data, 1 cycle after each LSB.
//  T2 I2S, f16, stereo: L=0xBEEF, R=0xCAFE with 1-bit delay -> rx_data 0xBEEF_0000 / 0xCAFE_0000.
//     ws=0 slot tagged left.
//  T3 enable mid-slot (rx_en rises 5 bits into L) -> partial word dropped.
//     The next full R and L words are received correctly.
//  T4 rx_full=1 at the R emit -> no rx_wen, overrun=1.
//     err_clr pulse -> overrun=0. The following words are written normally.
//  T5 LJ f32, ws toggles after 20 bits -> word = 20 bits << 12 emitted, slot_err=1.
//     The next slot is received intact.
//  T6 stereo=0, I2S f32: 4 frames -> exactly 4 rx_wen, all rx_right=0.
//     preset pulse mid-word -> all outputs 0, resync on the next slot start.

Source files
------------

// File: rtl/i2s_rx_deser.sv
// Serial receive deserializer for I2S / MSB-justified audio: detects slot starts from ws,
// assembles MSB-aligned left/right words and strobes them into the Rx FIFO.
module i2s_rx_deser #(
   parameter int DW = 32
) (
   input  logic          sclk,
   input  logic          preset,
   input  logic          rx_en,
   input  logic          frame_size,
   input  logic          standard,
   input  logic          stereo,
   input  logic          ws,
   input  logic          sd,
   input  logic          rx_full,
   input  logic          err_clr,
   output logic          rx_wen,
   output logic [DW-1:0] rx_data,
   output logic          rx_right,
   output logic          overrun,
   output logic          slot_err
);
   typedef enum logic [1:0] {IDLE, SYNC, SHIFT, HOLD} state_t;
   localparam int CW = $clog2(DW) + 1;

   state_t        state_q, state_d;
   logic          ws_q;
   logic          chg_dly_q, chg_dly_d;
   logic [DW-1:0] shreg_q, shreg_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fsz_q, fsz_d;
   logic          std_q, std_d;
   logic          stereo_q, stereo_d;
   logic          right_q, right_d;
   logic          rx_wen_q, rx_wen_d;
   logic [DW-1:0] rx_data_q, rx_data_d;
   logic          rx_right_q, rx_right_d;
   logic          overrun_q, overrun_d;
   logic          slot_err_q, slot_err_d;

   logic          chg, std_eff, start, new_right, last_bit;
   logic          emit, early, keep;
   logic [DW-1:0] shift_in, emit_word;
   logic [CW-1:0] cnt_inc, wlen;
   logic [CW:0]   sh_amt;

   // Slot settings are frozen once a slot is running; the live inputs only matter while syncing.
   always_comb begin
      chg       = ws ^ ws_q;
      std_eff   = (state_q == SHIFT || state_q == HOLD) ? std_q : standard;
      start     = std_eff ? chg : chg_dly_q;
      new_right = std_eff ? ~ws : ws_q;
      wlen      = fsz_q ? CW'(DW) : CW'(DW / 2);
      cnt_inc   = cnt_q + CW'(1);
      last_bit  = (cnt_inc == wlen);
      shift_in  = {shreg_q[DW-2:0], sd};
      sh_amt    = (CW + 1)'(DW) - {1'b0, cnt_q};
      chg_dly_d = chg & (state_q != IDLE);
   end

   always_ff @(posedge sclk or negedge preset) begin
      if (!preset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rx_en) state_d = SYNC;
         SYNC:    if (!rx_en) state_d = IDLE;
                  else if (start) state_d = SHIFT;
         SHIFT:   if (start) state_d = rx_en ? SHIFT : IDLE;
                  else if (last_bit) state_d = rx_en ? HOLD : IDLE;
         HOLD:    if (start) state_d = rx_en ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      fsz_d     = fsz_q;
      std_d     = std_q;
      stereo_d  = stereo_q;
      right_d   = right_q;
      emit      = 1'b0;
      early     = 1'b0;
      emit_word = '0;
      if (state_q == SHIFT) begin
         if (start) begin
            // Slot cut short: flush what arrived, left-aligned with zero padding.
            emit      = 1'b1;
            early     = 1'b1;
            emit_word = shreg_q << sh_amt;
         end else begin
            shreg_d = shift_in;
            cnt_d   = cnt_inc;
            if (last_bit) begin
               emit      = 1'b1;
               emit_word = fsz_q ? shift_in : {shift_in[DW/2-1:0], {(DW/2){1'b0}}};
            end
         end
      end
      if (start && rx_en && state_q != IDLE) begin
         shreg_d  = {{(DW-1){1'b0}}, sd};
         cnt_d    = CW'(1);
         fsz_d    = frame_size;
         std_d    = standard;
         stereo_d = stereo;
         right_d  = new_right;
      end
      keep       = emit & (stereo_q | ~right_q);
      rx_wen_d   = keep & ~rx_full;
      rx_data_d  = rx_wen_d ? emit_word : rx_data_q;
      rx_right_d = rx_wen_d ? right_q : rx_right_q;
      overrun_d  = err_clr ? 1'b0 : (overrun_q | (keep & rx_full));
      slot_err_d = err_clr ? 1'b0 : (slot_err_q | (keep & early));
   end

   always_ff @(posedge sclk or negedge preset) begin
      if (!preset) begin
         ws_q       <= 1'b0;
         chg_dly_q  <= 1'b0;
         shreg_q    <= '0;
         cnt_q      <= '0;
         fsz_q      <= 1'b0;
         std_q      <= 1'b0;
         stereo_q   <= 1'b0;
         right_q    <= 1'b0;
         rx_wen_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_right_q <= 1'b0;
         overrun_q  <= 1'b0;
         slot_err_q <= 1'b0;
      end else begin
         ws_q       <= ws;
         chg_dly_q  <= chg_dly_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         fsz_q      <= fsz_d;
         std_q      <= std_d;
         stereo_q   <= stereo_d;
         right_q    <= right_d;
         rx_wen_q   <= rx_wen_d;
         rx_data_q  <= rx_data_d;
         rx_right_q <= rx_right_d;
         overrun_q  <= overrun_d;
         slot_err_q <= slot_err_d;
      end
   end

   assign rx_wen   = rx_wen_q;
   assign rx_data  = rx_data_q;
   assign rx_right = rx_right_q;
   assign overrun  = overrun_q;
   assign slot_err = slot_err_q;
endmodule
